// File: rtl/axi4_inner_write_arbiter_pkg.sv
// Shared constants for the two-requester inner write-channel arbiter.
// State encoding and requester vector type used by the arbiter and its bus.
package axi4_inner_write_arbiter_pkg;

    localparam int NumRequesters = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    typedef logic [NumRequesters-1:0] req_vec_t;

endpackage

// File: rtl/axi4_inner_write_arbiter_if.sv
// Requester, inner-interface and status signals of the write arbiter.
// master is the arbiter's view, slave is the surrounding fabric's view.
interface axi4_inner_write_arbiter_if #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16
);
    import axi4_inner_write_arbiter_pkg::*;

    logic [AddressWidth-1:0]       S0_AWADDR,  S1_AWADDR;
    logic [InnerIFLengthWidth-1:0] S0_AWLEN,   S1_AWLEN;
    logic                          S0_AWVALID, S1_AWVALID;
    logic                          S0_AWREADY, S1_AWREADY;
    logic [DataWidth-1:0]          S0_WDATA,   S1_WDATA;
    logic                          S0_WLAST,   S1_WLAST;
    logic                          S0_WVALID,  S1_WVALID;
    logic                          S0_WREADY,  S1_WREADY;

    logic [AddressWidth-1:0]       M_AWADDR;
    logic [InnerIFLengthWidth-1:0] M_AWLEN;
    logic                          M_AWVALID;
    logic                          M_AWREADY;
    logic [DataWidth-1:0]          M_WDATA;
    logic                          M_WLAST;
    logic                          M_WVALID;
    logic                          M_WREADY;

    req_vec_t                      oGrant;
    logic                          oLengthError;

    modport master (
        input  S0_AWADDR, S1_AWADDR, S0_AWLEN, S1_AWLEN,
        input  S0_AWVALID, S1_AWVALID,
        output S0_AWREADY, S1_AWREADY,
        input  S0_WDATA, S1_WDATA, S0_WLAST, S1_WLAST,
        input  S0_WVALID, S1_WVALID,
        output S0_WREADY, S1_WREADY,
        output M_AWADDR, M_AWLEN, M_AWVALID,
        input  M_AWREADY,
        output M_WDATA, M_WLAST, M_WVALID,
        input  M_WREADY,
        output oGrant, oLengthError
    );

    modport slave (
        output S0_AWADDR, S1_AWADDR, S0_AWLEN, S1_AWLEN,
        output S0_AWVALID, S1_AWVALID,
        input  S0_AWREADY, S1_AWREADY,
        output S0_WDATA, S1_WDATA, S0_WLAST, S1_WLAST,
        output S0_WVALID, S1_WVALID,
        input  S0_WREADY, S1_WREADY,
        input  M_AWADDR, M_AWLEN, M_AWVALID,
        output M_AWREADY,
        input  M_WDATA, M_WLAST, M_WVALID,
        output M_WREADY,
        input  oGrant, oLengthError
    );

endinterface

// File: rtl/axi4_inner_write_arbiter_rr.sv
// Two-way round-robin pick: the requester not served last wins a tie.
// The pointer moves only when the caller commits the grant via advance.
module rr_arbiter_2
    import axi4_inner_write_arbiter_pkg::*;
(
    input  logic     iClock,
    input  logic     iReset,
    input  req_vec_t request,
    input  logic     advance,
    output req_vec_t grant
);

    // Set when requester 1 was served last; reset favours requester 0.
    logic r_last_one;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_last_one <= 1'b1;
        end else if (advance) begin
            r_last_one <= grant[1];
        end
    end

    always_comb begin
        grant = request;
        if (request == 2'b11) begin
            grant = r_last_one ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi4_inner_write_arbiter.sv
// Arbitrates two burst requesters onto one inner write command/data port.
// Bursts end on WLAST or on the last counted beat, whichever comes first.
module axi4_inner_write_arbiter
    import axi4_inner_write_arbiter_pkg::*;
#(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16
) (
    input logic                        iClock,
    input logic                        iReset,
    axi4_inner_write_arbiter_if.master bus
);

    logic [1:0]                    r_state;
    req_vec_t                      r_grant;
    logic [InnerIFLengthWidth-1:0] r_count;

    req_vec_t                      w_request;
    req_vec_t                      w_rr_grant;
    logic                          w_sel;
    logic                          w_in_addr;
    logic                          w_in_data;
    logic [AddressWidth-1:0]       w_awaddr;
    logic [InnerIFLengthWidth-1:0] w_awlen;
    logic                          w_awvalid;
    logic [DataWidth-1:0]          w_wdata;
    logic                          w_wlast;
    logic                          w_wvalid;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_cnt_zero;
    logic                          w_burst_end;
    logic                          w_regrant;

    assign w_request = {bus.S1_AWVALID, bus.S0_AWVALID};
    assign w_sel     = r_grant[1];
    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);

    assign w_awaddr  = w_sel ? bus.S1_AWADDR  : bus.S0_AWADDR;
    assign w_awlen   = w_sel ? bus.S1_AWLEN   : bus.S0_AWLEN;
    assign w_awvalid = w_sel ? bus.S1_AWVALID : bus.S0_AWVALID;
    assign w_wdata   = w_sel ? bus.S1_WDATA   : bus.S0_WDATA;
    assign w_wlast   = w_sel ? bus.S1_WLAST   : bus.S0_WLAST;
    assign w_wvalid  = w_sel ? bus.S1_WVALID  : bus.S0_WVALID;

    assign w_aw_hs     = w_in_addr && w_awvalid && bus.M_AWREADY;
    assign w_w_hs      = w_in_data && w_wvalid && bus.M_WREADY;
    assign w_cnt_zero  = (r_count == '0);
    assign w_burst_end = w_w_hs && (w_wlast || w_cnt_zero);
    assign w_regrant   = ((r_state == ST_IDLE) || w_burst_end)
                      && (w_request != '0);

    rr_arbiter_2 u_rr (
        .iClock  (iClock),
        .iReset  (iReset),
        .request (w_request),
        .advance (w_regrant),
        .grant   (w_rr_grant)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_regrant) begin
                        r_state <= ST_ADDR;
                        r_grant <= w_rr_grant;
                    end
                end
                ST_ADDR: begin
                    if (w_aw_hs) begin
                        r_state <= ST_DATA;
                        r_count <= w_awlen;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_count <= r_count - 1'b1;
                    end
                    // No pending command leaves w_rr_grant at zero.
                    if (w_burst_end) begin
                        r_state <= w_regrant ? ST_ADDR : ST_IDLE;
                        r_grant <= w_rr_grant;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.M_AWADDR  = w_awaddr;
    assign bus.M_AWLEN   = w_awlen;
    assign bus.M_AWVALID = w_in_addr && w_awvalid;
    assign bus.M_WDATA   = w_wdata;
    assign bus.M_WLAST   = w_in_data && (w_wlast || w_cnt_zero);
    assign bus.M_WVALID  = w_in_data && w_wvalid;

    assign bus.S0_AWREADY = w_in_addr && r_grant[0] && bus.M_AWREADY;
    assign bus.S1_AWREADY = w_in_addr && r_grant[1] && bus.M_AWREADY;
    assign bus.S0_WREADY  = w_in_data && r_grant[0] && bus.M_WREADY;
    assign bus.S1_WREADY  = w_in_data && r_grant[1] && bus.M_WREADY;

    assign bus.oGrant       = r_grant;
    assign bus.oLengthError = w_burst_end && (w_wlast != w_cnt_zero);

endmodule

// File: doc/axi4_inner_write_arbiter.md
AXI4_INNER_WRITE_ARBITER -- requirements
Module: axi4_inner_write_arbiter

Interface
REQ-001 Parameter AddressWidth, default 32, width of all AWADDR ports.
REQ-002 Parameter DataWidth, default 32, width of all WDATA ports.
REQ-003 Parameter InnerIFLengthWidth, default 16, width of all AWLEN ports.
REQ-004 iClock  input  1  sole clock; one clock, all logic on rising edge.
REQ-005 iReset  input  1  reset, synchronous, active-high.
REQ-006 Sn_AWADDR (n=0,1)  input  AddressWidth  requester n burst start address.
REQ-007 Sn_AWLEN  input  InnerIFLengthWidth  requester n burst length, encoded as beats minus one.
REQ-008 Sn_AWVALID  input  1  requester n command valid.
REQ-009 Sn_AWREADY  output  1  requester n command accepted.
REQ-010 Sn_WDATA  input  DataWidth  requester n write beat.
REQ-011 Sn_WLAST  input  1  requester n final beat marker.
REQ-012 Sn_WVALID / Sn_WREADY  input / output  1  requester n beat handshake.
REQ-013 M_AWADDR, M_AWLEN, M_AWVALID  output  AddressWidth / InnerIFLengthWidth / 1  command to the write-channel inner interface.
REQ-014 M_AWREADY  input  1  inner-interface command ready.
REQ-015 M_WDATA, M_WLAST, M_WVALID  output  DataWidth / 1 / 1  beats to the inner interface.
REQ-016 M_WREADY  input  1  inner-interface beat ready.
REQ-017 oGrant  output  2  one-hot current owner, 2'b00 when idle.
REQ-018 oLengthError  output  1  one-cycle pulse on a length/WLAST mismatch.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-020 In IDLE, if any Sn_AWVALID=1, the FSM SHALL register a grant and enter ADDR on the next edge, so M_AWVALID rises one cycle after the request.
REQ-021 The grant SHALL be round-robin: if both requesters are requesting, the requester not served last wins; after reset, requester 0 wins.
REQ-022 In ADDR, M_AWADDR/M_AWLEN/M_AWVALID SHALL mux from the granted requester, and Sn_AWREADY(granted) SHALL equal M_AWREADY; on that handshake the FSM SHALL load the beat counter with AWLEN and enter DATA.
REQ-023 In DATA, M_WDATA/M_WLAST/M_WVALID SHALL mux from the granted requester, and Sn_WREADY(granted) SHALL equal M_WREADY; the counter SHALL decrement on each beat handshake.
REQ-024 The burst SHALL end on the first beat handshake with WLAST=1 or counter=0, whichever occurs first.
REQ-025 If, at burst end, WLAST and counter=0 disagree, oLengthError SHALL pulse for one cycle and M_WLAST SHALL be forced to 1 on that beat.
REQ-026 At burst end, if any Sn_AWVALID=1, the FSM SHALL regrant per round-robin and go directly to ADDR (no idle bubble); otherwise it SHALL go to IDLE.
REQ-027 A non-granted requester SHALL see AWREADY=0 and WREADY=0 in all states; all READY outputs SHALL be 0 in IDLE.
REQ-028 W beats SHALL NOT pass before their command is accepted: M_WVALID=0 outside DATA.
REQ-029 The grant SHALL NOT change while in ADDR or DATA, regardless of the other requester.
REQ-030 AWLEN=0 SHALL produce a one-beat burst; an AWLEN of all-ones SHALL count 2^InnerIFLengthWidth beats without wrap error.

Reset
REQ-031 While iReset=1, on the next edge: state=IDLE, oGrant=0, M_AWVALID=0, M_WVALID=0, M_WLAST=0, all Sn_*READY=0, oLengthError=0, round-robin pointer favours requester 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no further beats forwarded.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10) and the requester count constant (2).
REQ-034 The round-robin decision SHALL be a sub-module named rr_arbiter_2 (inputs: request[1:0], advance; output: one-hot grant).

Verification
REQ-035 S0 only, AWLEN=3, 4 beats with WLAST on beat 4, M_*READY=1 -> M_AWVALID rises 1 cycle after S0_AWVALID; 4 beats forwarded; oGrant 01->00.
REQ-036 S0 and S1 request simultaneously after reset -> S0 served first, then S1 goes directly to ADDR on the S0 last-beat cycle with no idle cycle.
REQ-037 M_WREADY toggled 1/0 every cycle during an 8-beat burst -> exactly 8 handshakes; S1_WREADY stays 0 throughout.
REQ-038 S1, AWLEN=3, WLAST on beat 2 -> oLengthError pulses at beat 2, FSM returns to IDLE; AWLEN=1 with no WLAST -> M_WLAST forced to 1 on beat 2, error pulse.
REQ-039 iReset asserted on beat 2 of a 4-beat burst -> next cycle all VALID/READY=0, oGrant=0; a new S1 request is then served normally.
